// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: stall/flush, EX forwarding
// selects, post-branch fetch-redirect shadow and stall watchdog. Optional perf counters via HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int FETCH_LATENCY = 0,
  parameter int STALL_TIMEOUT = 255,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_imem_valid,
  input  logic [1:0]           i_rs1_D,
  input  logic [1:0]           i_rs2_D,
  input  logic                 i_use_rs1_D,
  input  logic                 i_use_rs2_D,
  input  logic [1:0]           i_rs1_E,
  input  logic [1:0]           i_rs2_E,
  input  logic [1:0]           i_rd_E,
  input  logic                 i_memRead_E,
  input  logic                 i_regWrite_E,
  input  logic                 i_pc_src_E,
  input  logic [1:0]           i_rd_M,
  input  logic                 i_regWrite_M,
  input  logic [1:0]           i_rd_W,
  input  logic                 i_regWrite_W,
  output logic                 o_stallF,
  output logic                 o_stallD,
  output logic                 o_flushD,
  output logic                 o_flushE,
  output logic [1:0]           o_fwdA_E,
  output logic [1:0]           o_fwdB_E,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0] o_stall_cycles,
  output logic [CNT_WIDTH-1:0] o_flush_cycles,
`endif
  output logic                 o_timeout
);

  localparam logic [15:0] LIMIT  = 16'(STALL_TIMEOUT);
  localparam logic [15:0] RELOAD = 16'(FETCH_LATENCY);

  typedef enum logic {RUN, REDIRECT} state_t;

  state_t      state, state_nxt;
  logic [15:0] rc, rc_nxt;
  logic [15:0] stall_cnt, stall_cnt_nxt;
  logic        lu;

  assign lu = i_memRead_E & i_regWrite_E &
              ((i_use_rs1_D & (i_rd_E == i_rs1_D)) | (i_use_rs2_D & (i_rd_E == i_rs2_D)));

  always_comb begin
    o_stallF  = 1'b0;
    o_stallD  = 1'b0;
    o_flushD  = 1'b0;
    o_flushE  = 1'b0;
    o_fwdA_E  = 2'b00;
    o_fwdB_E  = 2'b00;
    state_nxt = state;
    rc_nxt    = rc;
    if (i_rst_n) begin
      // M result is younger than W, so it wins when both match
      if (i_regWrite_M && i_rd_M == i_rs1_E)      o_fwdA_E = 2'b10;
      else if (i_regWrite_W && i_rd_W == i_rs1_E) o_fwdA_E = 2'b01;
      if (i_regWrite_M && i_rd_M == i_rs2_E)      o_fwdB_E = 2'b10;
      else if (i_regWrite_W && i_rd_W == i_rs2_E) o_fwdB_E = 2'b01;

      if (i_pc_src_E) begin
        o_flushD = 1'b1;
        o_flushE = 1'b1;
        if (FETCH_LATENCY > 0) begin
          state_nxt = REDIRECT;
          rc_nxt    = RELOAD;
        end
      end else if (state == REDIRECT) begin
        // stale imem output still draining; load-use is moot since D gets flushed
        o_flushD = 1'b1;
        o_stallF = ~i_imem_valid;
        rc_nxt   = rc - 16'd1;
        if (rc == 16'd1) state_nxt = RUN;
      end else if (lu) begin
        o_stallF = 1'b1;
        o_stallD = 1'b1;
        o_flushE = 1'b1;
      end else if (!i_imem_valid) begin
        o_stallF = 1'b1;
        o_flushD = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_nxt = 16'd0;
    if (o_stallF) stall_cnt_nxt = (stall_cnt >= LIMIT) ? stall_cnt : stall_cnt + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= RUN;
      rc        <= 16'd0;
      stall_cnt <= 16'd0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      rc        <= rc_nxt;
      stall_cnt <= stall_cnt_nxt;
      if (o_stallF && stall_cnt_nxt == LIMIT) o_timeout <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_stall_cycles <= '0;
      o_flush_cycles <= '0;
    end else begin
      if (o_stallF)             o_stall_cycles <= o_stall_cycles + CNT_WIDTH'(1);
      if (o_flushD || o_flushE) o_flush_cycles <= o_flush_cycles + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (FETCH_LATENCY=2, STALL_TIMEOUT=4).
module tb_hazard_ctrl;
  localparam int CW = 32;

  logic i_clk = 1'b0, i_rst_n = 1'b0, i_imem_valid = 1'b1;
  logic [1:0] i_rs1_D = '0, i_rs2_D = '0, i_rs1_E = '0, i_rs2_E = '0;
  logic [1:0] i_rd_E = '0, i_rd_M = '0, i_rd_W = '0;
  logic i_use_rs1_D = 0, i_use_rs2_D = 0, i_memRead_E = 0, i_regWrite_E = 0;
  logic i_pc_src_E = 0, i_regWrite_M = 0, i_regWrite_W = 0;
  logic o_stallF, o_stallD, o_flushD, o_flushE, o_timeout;
  logic [1:0] o_fwdA_E, o_fwdB_E;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] o_stall_cycles, o_flush_cycles;
`endif

  int checks = 0, failures = 0;

  hazard_ctrl #(.FETCH_LATENCY(2), .STALL_TIMEOUT(4), .CNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_imem_valid(i_imem_valid),
    .i_rs1_D(i_rs1_D), .i_rs2_D(i_rs2_D), .i_use_rs1_D(i_use_rs1_D), .i_use_rs2_D(i_use_rs2_D),
    .i_rs1_E(i_rs1_E), .i_rs2_E(i_rs2_E), .i_rd_E(i_rd_E),
    .i_memRead_E(i_memRead_E), .i_regWrite_E(i_regWrite_E), .i_pc_src_E(i_pc_src_E),
    .i_rd_M(i_rd_M), .i_regWrite_M(i_regWrite_M), .i_rd_W(i_rd_W), .i_regWrite_W(i_regWrite_W),
    .o_stallF(o_stallF), .o_stallD(o_stallD), .o_flushD(o_flushD), .o_flushE(o_flushE),
    .o_fwdA_E(o_fwdA_E), .o_fwdB_E(o_fwdB_E),
`ifdef HAZARD_PERF_CNT_EN
    .o_stall_cycles(o_stall_cycles), .o_flush_cycles(o_flush_cycles),
`endif
    .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  // ctl = {stallF, stallD, flushD, flushE}
  task automatic chk(input string tag, input logic [3:0] ctl, input logic [1:0] fa,
                     input logic [1:0] fb, input logic to);
    logic [8:0] obs, exp;
    #1;
    obs = {o_stallF, o_stallD, o_flushD, o_flushE, o_fwdA_E, o_fwdB_E, o_timeout};
    exp = {ctl, fa, fb, to};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b (stF stD flD flE fA fB to)", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_pipe();
    i_memRead_E = 0; i_regWrite_E = 0; i_use_rs1_D = 0; i_use_rs2_D = 0;
    i_regWrite_M = 0; i_regWrite_W = 0; i_pc_src_E = 0; i_imem_valid = 1;
    i_rs1_D = 0; i_rs2_D = 0; i_rs1_E = 0; i_rs2_E = 0; i_rd_E = 0; i_rd_M = 0; i_rd_W = 0;
  endtask

  initial begin
    // reset: combinational outputs forced low despite hazard-looking inputs
    i_imem_valid = 0; i_regWrite_M = 1; i_rd_M = 0; i_pc_src_E = 1;
    chk("reset_forced", 4'b0000, 2'b00, 2'b00, 1'b0);
    tick(); tick();
    clear_pipe(); i_rst_n = 1;
    chk("idle", 4'b0000, 2'b00, 2'b00, 1'b0);

    // load-use on rs1
    i_memRead_E = 1; i_regWrite_E = 1; i_rd_E = 2; i_rs1_D = 2; i_use_rs1_D = 1;
    chk("lu_rs1", 4'b1101, 2'b00, 2'b00, 1'b0);
    tick();
    i_memRead_E = 0; i_regWrite_E = 0; i_rs1_E = 2; i_regWrite_M = 1; i_rd_M = 2;
    chk("lu_after", 4'b0000, 2'b10, 2'b00, 1'b0);
    tick(); clear_pipe();
    // match but operand unused -> no hazard; then rs2 path
    i_memRead_E = 1; i_regWrite_E = 1; i_rd_E = 1; i_rs1_D = 1; i_use_rs1_D = 0;
    chk("lu_unused", 4'b0000, 2'b00, 2'b00, 1'b0);
    i_rs2_D = 1; i_use_rs2_D = 1;
    chk("lu_rs2", 4'b1101, 2'b00, 2'b00, 1'b0);
    tick(); clear_pipe();

    // forwarding priority
    i_regWrite_M = 1; i_rd_M = 3; i_regWrite_W = 1; i_rd_W = 3; i_rs1_E = 3; i_rs2_E = 1;
    chk("fwd_m_prio", 4'b0000, 2'b10, 2'b00, 1'b0);
    i_regWrite_M = 0;
    chk("fwd_w", 4'b0000, 2'b01, 2'b00, 1'b0);
    i_rs2_E = 3; i_regWrite_M = 1;
    chk("fwd_both_m", 4'b0000, 2'b10, 2'b10, 1'b0);
    i_rd_W = 0; i_rs2_E = 0;
    chk("fwd_r0", 4'b0000, 2'b10, 2'b01, 1'b0);
    clear_pipe();

    // branch with two-cycle redirect shadow
    i_pc_src_E = 1;
    chk("br", 4'b0011, 2'b00, 2'b00, 1'b0);
    tick(); i_pc_src_E = 0;
    i_memRead_E = 1; i_regWrite_E = 1; i_rd_E = 2; i_rs1_D = 2; i_use_rs1_D = 1;
    chk("redir1_lu_supp", 4'b0010, 2'b00, 2'b00, 1'b0);
    tick(); clear_pipe(); i_imem_valid = 0;
    chk("redir2_nofetch", 4'b1010, 2'b00, 2'b00, 1'b0);
    tick(); i_imem_valid = 1;
    chk("redir_done", 4'b0000, 2'b00, 2'b00, 1'b0);

    // branch beats load-use; branch in REDIRECT reloads the count
    i_memRead_E = 1; i_regWrite_E = 1; i_rd_E = 2; i_rs1_D = 2; i_use_rs1_D = 1; i_pc_src_E = 1;
    chk("br_over_lu", 4'b0011, 2'b00, 2'b00, 1'b0);
    tick(); clear_pipe();
    chk("rl_a", 4'b0010, 2'b00, 2'b00, 1'b0);
    tick(); i_pc_src_E = 1;
    chk("rl_br", 4'b0011, 2'b00, 2'b00, 1'b0);
    tick(); i_pc_src_E = 0;
    chk("rl_c", 4'b0010, 2'b00, 2'b00, 1'b0);
    tick();
    chk("rl_d", 4'b0010, 2'b00, 2'b00, 1'b0);
    tick();
    chk("rl_run", 4'b0000, 2'b00, 2'b00, 1'b0);

    // fetch wait + watchdog (timeout after 4th stalled edge)
    i_imem_valid = 0;
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("fw_%0d", i), 4'b1010, 2'b00, 2'b00, (i >= 5));
      tick();
    end
    i_imem_valid = 1;
    chk("to_sticky", 4'b0000, 2'b00, 2'b00, 1'b1);
    tick();
    i_imem_valid = 0; i_memRead_E = 1; i_regWrite_E = 1; i_rd_E = 3; i_rs2_D = 3; i_use_rs2_D = 1;
    chk("lu_over_fw", 4'b1101, 2'b00, 2'b00, 1'b1);
    tick(); clear_pipe();
    chk("to_sticky2", 4'b0000, 2'b00, 2'b00, 1'b1);

    // reset while in REDIRECT
    i_pc_src_E = 1;
    tick(); i_pc_src_E = 0; i_rst_n = 0;
    i_regWrite_W = 1; i_rd_W = 1; i_rs1_E = 1;
    chk("rst_redir", 4'b0000, 2'b00, 2'b00, 1'b1);
    tick(); i_rst_n = 1; clear_pipe();
    chk("rst_release", 4'b0000, 2'b00, 2'b00, 1'b0);
    tick();
    chk("rst_run", 4'b0000, 2'b00, 2'b00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage 18-bit-instruction / 36-bit-data pipeline.
- Observes decode, execute, memory and writeback stage register fields and the fetch-valid handshake.
- Drives stall/flush into the IF/ID and ID/EX pipeline registers and forwarding selects into the EX operand muxes.
- Holds a redirect state machine for fetch latency after taken branches, plus a stall watchdog.

Parameters:
- FETCH_LATENCY, 0: extra cycles IF/ID is flushed after a taken branch (stale instruction-memory output).
- STALL_TIMEOUT, 255: consecutive o_stallF cycles before o_timeout sets; 1..65535.
- CNT_WIDTH, 32: perf counter width (only with the optional feature).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  synchronous active-low reset
- i_imem_valid  in  1  fetch instruction valid this cycle
- i_rs1_D, i_rs2_D  in  2 each  decode source registers
- i_use_rs1_D, i_use_rs2_D  in  1 each  decode instruction reads rs1/rs2
- i_rs1_E, i_rs2_E  in  2 each  execute source registers
- i_rd_E  in  2  execute destination
- i_memRead_E, i_regWrite_E, i_pc_src_E  in  1 each  execute load / write / taken branch
- i_rd_M, i_regWrite_M  in  2/1  memory stage destination, write enable
- i_rd_W, i_regWrite_W  in  2/1  writeback destination, write enable
- o_stallF, o_stallD  out  1 each  hold PC / hold IF/ID
- o_flushD, o_flushE  out  1 each  clear IF/ID / clear ID/EX
- o_fwdA_E, o_fwdB_E  out  2 each  operand select: 00 regfile, 01 W, 10 M
- o_timeout  out  1  sticky stall-watchdog flag

Behaviour:
- Reset:
  - The reset is synchronous and active-low: while i_rst_n=0 at a rising i_clk edge, state=RUN, redirect count=0, stall count=0, o_timeout=0.
  - All combinational outputs are forced to 0 whenever i_rst_n=0.
- Output timing: stall/flush/fwd are combinational from inputs and current state (0-cycle latency). State updates on the rising edge.
- States:
  - RUN: normal operation.
  - REDIRECT: post-branch fetch shadow, down-counter rc.
- Priority each cycle: branch > redirect shadow > load-use > fetch wait.
- Branch, i_pc_src_E=1 (any state):
  - Drive o_flushD=1, o_flushE=1, o_stallF=0, o_stallD=0.
  - If FETCH_LATENCY>0, go to REDIRECT with rc=FETCH_LATENCY; else stay in RUN.
  - A branch while in REDIRECT reloads rc.
- REDIRECT with no branch:
  - Drive o_flushD=1, o_flushE=0, o_stallD=0, o_stallF=~i_imem_valid.
  - rc decrements every cycle; go to RUN when rc==1 at the edge.
  - Load-use detection is suppressed in this state.
- Load-use (RUN, no branch):
  - Condition: lu = i_memRead_E & i_regWrite_E & ((i_use_rs1_D & i_rd_E==i_rs1_D) | (i_use_rs2_D & i_rd_E==i_rs2_D)).
  - Response: o_stallF=1, o_stallD=1, o_flushE=1, o_flushD=0. Exactly one bubble per load.
- Fetch wait (RUN, no branch, no lu), i_imem_valid=0:
  - Drive o_stallF=1, o_flushD=1 (bubble into decode), o_stallD=0, o_flushE=0.
  - If lu and fetch wait coincide, load-use response wins: o_flushD=0 and IF/ID is held.
- Forwarding, independent of state:
  - o_fwdA_E=10 if i_regWrite_M & i_rd_M==i_rs1_E; else 01 if i_regWrite_W & i_rd_W==i_rs1_E; else 00.
  - o_fwdB_E: same rule using i_rs2_E.
  - M has priority over W. Register 0 is not special.
- Watchdog:
  - The 16-bit stall count increments on each edge with o_stallF=1 and clears on each edge with o_stallF=0. It saturates at STALL_TIMEOUT.
  - o_timeout sets the edge the count reaches STALL_TIMEOUT and stays 1 until reset.
- Reset mid-redirect or mid-stall: aborts immediately to RUN with counters cleared.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined:
  - Adds outputs o_stall_cycles and o_flush_cycles, CNT_WIDTH each, reset to 0.
  - o_stall_cycles increments on each edge with o_stallF=1; o_flush_cycles increments on each edge with o_flushD|o_flushE=1.
  - Both wrap modulo 2^CNT_WIDTH.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Load-use: E has lw to rd=2; D has add using rs1=2, use_rs1=1 -> one cycle of stallF=1, stallD=1, flushE=1. The next cycle has all 0 and fwdA_E=10.
- Forwarding priority: regWrite_M=1, rd_M=3; regWrite_W=1, rd_W=3; rs1_E=3, rs2_E=1 -> fwdA_E=10, fwdB_E=00. Dropping regWrite_M gives fwdA_E=01.
- Branch with FETCH_LATENCY=2: pc_src_E=1 for 1 cycle -> flushD=1, flushE=1 that cycle, then flushD=1, flushE=0 for exactly 2 cycles, then RUN.
- Branch simultaneous with load-use -> stallF=0, stallD=0, flushD=1, flushE=1.
- Fetch wait with STALL_TIMEOUT=4: imem_valid=0 for 5 cycles -> stallF=1 and flushD=1 each cycle, o_timeout rises after the 4th edge and stays 1 after imem_valid=1. Only i_rst_n=0 at an edge clears it.
- Reset while in REDIRECT with rc=2: i_rst_n=0 for one edge -> all outputs 0 during reset; after release, state is RUN and flushD=0 with valid fetch.
